// File: rtl/dcache_data_array.sv
// Four-way L1 data-cache data array: byte-masked writes, 1-cycle synchronous reads,
// one even-parity bit per stored byte with per-way parity-error reporting.
module dcache_data_array #(
    parameter int ADDR_W = 12,
    parameter int NWAYS  = 4,
    parameter int DEPTH  = 2 ** (ADDR_W - 2)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_req_valid,
    input  logic [ADDR_W-1:0] io_req_bits_addr,
    input  logic              io_req_bits_write,
    input  logic [31:0]       io_req_bits_wdata,
    input  logic [3:0]        io_req_bits_eccMask,
    input  logic [NWAYS-1:0]  io_req_bits_way_en,
    input  logic              io_req_bits_perr_inj,
    output logic              io_resp_valid,
    output logic [31:0]       io_resp_data_0,
    output logic [31:0]       io_resp_data_1,
    output logic [31:0]       io_resp_data_2,
    output logic [31:0]       io_resp_data_3,
    output logic [NWAYS-1:0]  io_resp_err
);

    localparam int IDX_W = ADDR_W - 2;

    // Handshake: a request is taken on every edge where io_req_valid=1 (no ready);
    // a read produces io_resp_valid=1 for exactly one cycle, one edge later.
    logic [IDX_W-1:0] w_idx;
    logic             w_wr;
    logic             w_rd;
    logic [1:0]       w_unused_addr;

    assign w_idx         = io_req_bits_addr[ADDR_W-1:2];
    assign w_unused_addr = io_req_bits_addr[1:0];
    assign w_wr          = io_req_valid & io_req_bits_write;
    assign w_rd          = io_req_valid & ~io_req_bits_write;

    logic [31:0]      r_mem     [NWAYS][DEPTH];
    logic [3:0]       r_par_mem [NWAYS][DEPTH];

    logic             r_resp_valid;
    logic [NWAYS-1:0] r_rd_en;
    logic [31:0]      r_data    [NWAYS];
    logic [3:0]       r_par     [NWAYS];
    logic [NWAYS-1:0] w_err;

    // Storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            for (int w = 0; w < NWAYS; w++) begin
                for (int b = 0; b < 4; b++) begin
                    if (io_req_bits_way_en[w] && io_req_bits_eccMask[b]) begin
                        r_mem[w][w_idx][8*b +: 8] <= io_req_bits_wdata[8*b +: 8];
                        r_par_mem[w][w_idx][b]    <= (^io_req_bits_wdata[8*b +: 8]) ^ io_req_bits_perr_inj;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_resp_valid <= 1'b0;
            r_rd_en      <= '0;
            for (int w = 0; w < NWAYS; w++) begin
                r_data[w] <= '0;
                r_par[w]  <= '0;
            end
        end else begin
            r_resp_valid <= w_rd;
            if (w_rd) begin
                r_rd_en <= io_req_bits_way_en;
                for (int w = 0; w < NWAYS; w++) begin
                    if (io_req_bits_way_en[w]) begin
                        r_data[w] <= r_mem[w][w_idx];
                        r_par[w]  <= r_par_mem[w][w_idx];
                    end
                end
            end
        end
    end

    // Error only for ways actually read by the request that produced this response.
    always_comb begin
        w_err = '0;
        for (int w = 0; w < NWAYS; w++) begin
            for (int b = 0; b < 4; b++) begin
                if ((^r_data[w][8*b +: 8]) != r_par[w][b]) begin
                    w_err[w] = 1'b1;
                end
            end
        end
        w_err = w_err & r_rd_en & {NWAYS{r_resp_valid}};
    end

    assign io_resp_valid  = r_resp_valid;
    assign io_resp_data_0 = r_data[0];
    assign io_resp_data_1 = r_data[1];
    assign io_resp_data_2 = r_data[2];
    assign io_resp_data_3 = r_data[3];
    assign io_resp_err    = w_err;

endmodule

// File: tb/tb_dcache_data_array.sv
// Directed table-driven bench for dcache_data_array plus hand-written reset sequences.
module tb_dcache_data_array;

    logic        clock;
    logic        reset;
    logic        io_req_valid;
    logic [11:0] io_req_bits_addr;
    logic        io_req_bits_write;
    logic [31:0] io_req_bits_wdata;
    logic [3:0]  io_req_bits_eccMask;
    logic [3:0]  io_req_bits_way_en;
    logic        io_req_bits_perr_inj;
    logic        io_resp_valid;
    logic [31:0] io_resp_data_0;
    logic [31:0] io_resp_data_1;
    logic [31:0] io_resp_data_2;
    logic [31:0] io_resp_data_3;
    logic [3:0]  io_resp_err;

    dcache_data_array dut (
        .clock                (clock),
        .reset                (reset),
        .io_req_valid         (io_req_valid),
        .io_req_bits_addr     (io_req_bits_addr),
        .io_req_bits_write    (io_req_bits_write),
        .io_req_bits_wdata    (io_req_bits_wdata),
        .io_req_bits_eccMask  (io_req_bits_eccMask),
        .io_req_bits_way_en   (io_req_bits_way_en),
        .io_req_bits_perr_inj (io_req_bits_perr_inj),
        .io_resp_valid        (io_resp_valid),
        .io_resp_data_0       (io_resp_data_0),
        .io_resp_data_1       (io_resp_data_1),
        .io_resp_data_2       (io_resp_data_2),
        .io_resp_data_3       (io_resp_data_3),
        .io_resp_err          (io_resp_err)
    );

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- vector table ----------------
    typedef struct {
        logic        valid;
        logic        write;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [3:0]  way_en;
        logic        perr;
        logic        exp_valid;
        logic [31:0] exp_d0;
        logic [31:0] exp_d1;
        logic [31:0] exp_d2;
        logic [31:0] exp_d3;
        logic [3:0]  exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp;
    int   n_fail;

    task automatic add(input logic v, input logic wr, input logic [11:0] a,
                       input logic [31:0] wd, input logic [3:0] m, input logic [3:0] we,
                       input logic pe, input logic ev, input logic [31:0] d0,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                       input logic [3:0] ee);
        vec_t t;
        t.valid = v; t.write = wr; t.addr = a; t.wdata = wd; t.mask = m; t.way_en = we;
        t.perr = pe; t.exp_valid = ev; t.exp_d0 = d0; t.exp_d1 = d1; t.exp_d2 = d2;
        t.exp_d3 = d3; t.exp_err = ee;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic ev,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3,
                             input logic [3:0] ee);
        check({tag, ".valid"}, idx, {31'd0, io_resp_valid}, {31'd0, ev});
        check({tag, ".data0"}, idx, io_resp_data_0, d0);
        check({tag, ".data1"}, idx, io_resp_data_1, d1);
        check({tag, ".data2"}, idx, io_resp_data_2, d2);
        check({tag, ".data3"}, idx, io_resp_data_3, d3);
        check({tag, ".err"},   idx, {28'd0, io_resp_err}, {28'd0, ee});
    endtask

    task automatic drive(input logic v, input logic wr, input logic [11:0] a,
                         input logic [31:0] wd, input logic [3:0] m, input logic [3:0] we,
                         input logic pe);
        io_req_valid         = v;
        io_req_bits_write    = wr;
        io_req_bits_addr     = a;
        io_req_bits_wdata    = wd;
        io_req_bits_eccMask  = m;
        io_req_bits_way_en   = we;
        io_req_bits_perr_inj = pe;
    endtask

    localparam logic [11:0] A_010 = 12'h010;
    localparam logic [11:0] A_020 = 12'h020;
    localparam logic [11:0] A_FFC = 12'hFFC;
    localparam logic [11:0] A_000 = 12'h000;

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Zero-fill the locations used below in every way so parity is well-defined.
        add(1, 1, A_010, 32'h0, 4'hf, 4'hf, 0,  0, 0, 0, 0, 0, 4'h0);
        add(1, 1, A_020, 32'h0, 4'hf, 4'hf, 0,  0, 0, 0, 0, 0, 4'h0);
        add(1, 1, A_FFC, 32'h0, 4'hf, 4'hf, 0,  0, 0, 0, 0, 0, 4'h0);
        add(1, 1, A_000, 32'h0, 4'hf, 4'hf, 0,  0, 0, 0, 0, 0, 4'h0);
        // Basic write then read of all ways
        add(1, 1, A_010, 32'hDEADBEEF, 4'hf, 4'b0100, 0,  0, 0, 0, 0, 0, 4'h0);
        add(1, 0, A_010, 32'h0, 4'h0, 4'hf, 0,  1, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        // Byte mask merge
        add(1, 1, A_020, 32'h11223344, 4'hf, 4'b0001, 0,  0, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        add(1, 1, A_020, 32'hAABBCCDD, 4'b0101, 4'b0001, 0,  0, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        add(1, 0, A_020, 32'h0, 4'h0, 4'hf, 0,  1, 32'h11BB33DD, 0, 0, 0, 4'h0);
        // Parity injection at top index
        add(1, 1, A_FFC, 32'h000000FF, 4'b0001, 4'b0010, 1,  0, 32'h11BB33DD, 0, 0, 0, 4'h0);
        add(1, 0, A_FFC, 32'h0, 4'h0, 4'b0010, 0,  1, 32'h11BB33DD, 32'hFF, 0, 0, 4'b0010);
        // Back-to-back reads
        add(1, 0, A_010, 32'h0, 4'h0, 4'hf, 0,  1, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        add(1, 0, A_020, 32'h0, 4'h0, 4'hf, 0,  1, 32'h11BB33DD, 0, 0, 0, 4'h0);
        add(1, 0, A_FFC, 32'h0, 4'h0, 4'b0010, 0,  1, 32'h11BB33DD, 32'hFF, 0, 0, 4'b0010);
        // Way1 holds bad-parity data but is not read: no error, data holds
        add(1, 0, A_010, 32'h0, 4'h0, 4'b0001, 0,  1, 0, 32'hFF, 0, 0, 4'h0);
        // Idle, mask-zero write, way-zero write: no state change
        add(0, 0, A_010, 32'h0, 4'h0, 4'hf, 0,  0, 0, 32'hFF, 0, 0, 4'h0);
        add(1, 1, A_010, 32'h12345678, 4'h0, 4'hf, 0,  0, 0, 32'hFF, 0, 0, 4'h0);
        add(1, 1, A_010, 32'h12345678, 4'hf, 4'h0, 0,  0, 0, 32'hFF, 0, 0, 4'h0);
        add(1, 0, A_010, 32'h0, 4'hf, 4'hf, 0,  1, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        // Index wrap: idx 0 and idx 1023 do not alias
        add(1, 1, A_000, 32'h0BADF00D, 4'hf, 4'b1000, 0,  0, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        add(1, 0, A_000, 32'h0, 4'h0, 4'b1000, 0,  1, 0, 0, 32'hDEADBEEF, 32'h0BADF00D, 4'h0);
        add(1, 0, A_FFC, 32'h0, 4'h0, 4'b1000, 0,  1, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        // Read immediately after write to same index
        add(1, 1, A_010, 32'h55AA55AA, 4'hf, 4'b0001, 0,  0, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        add(1, 0, A_010, 32'h0, 4'h0, 4'b0001, 0,  1, 32'h55AA55AA, 0, 32'hDEADBEEF, 0, 4'h0);
        // Read with no ways enabled: valid response, all data holds
        add(1, 0, A_010, 32'h0, 4'h0, 4'h0, 0,  1, 32'h55AA55AA, 0, 32'hDEADBEEF, 0, 4'h0);

        // ---------------- reset with valid read held ----------------
        reset = 1'b0;
        drive(1, 0, A_010, 32'h0, 4'h0, 4'hf, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            check_all("reset", c, 0, 0, 0, 0, 0, 4'h0);
        end
        @(negedge clock);
        drive(0, 0, A_010, 32'h0, 4'h0, 4'h0, 0);
        reset = 1'b1;

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].valid, vecs[i].write, vecs[i].addr, vecs[i].wdata,
                  vecs[i].mask, vecs[i].way_en, vecs[i].perr);
            @(posedge clock);
            #1;
            check_all("vec", i, vecs[i].exp_valid, vecs[i].exp_d0, vecs[i].exp_d1,
                      vecs[i].exp_d2, vecs[i].exp_d3, vecs[i].exp_err);
        end

        // ---------------- reset right after a read request ----------------
        @(negedge clock);
        drive(1, 0, A_010, 32'h0, 4'h0, 4'hf, 0);
        @(posedge clock);
        #1;
        check("midrst.pre_valid", 0, {31'd0, io_resp_valid}, 32'd1);
        drive(0, 0, A_010, 32'h0, 4'h0, 4'h0, 0);
        reset = 1'b0;
        #1;
        check_all("midrst.async", 0, 0, 0, 0, 0, 0, 4'h0);
        @(posedge clock);
        #1;
        check_all("midrst.hold", 0, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_all("midrst.idle", 0, 0, 0, 0, 0, 0, 4'h0);
        @(negedge clock);
        drive(1, 0, A_010, 32'h0, 4'h0, 4'b0100, 0);
        @(posedge clock);
        #1;
        check_all("midrst.reread", 0, 1, 0, 0, 32'hDEADBEEF, 0, 4'h0);
        @(negedge clock);
        drive(0, 0, A_010, 32'h0, 4'h0, 4'h0, 0);
        @(posedge clock);
        #1;
        check("midrst.after_valid", 0, {31'd0, io_resp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
